// File: rtl/spi_tx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tx_frame_ctrl
//  Description : Frame sequencer and write arbiter in front of the SPI TX
//                shift engine (sclk_tx domain). Round-robin arbitrates CPU
//                and DMA writes into a DEPTH-entry FIFO, presents the head
//                word to the shifter, pops one word per tx_start, counts
//                frames against spi_tnum_max, optionally runs one CRC frame,
//                and reports txe / busy / udr / done status.
//  Ports       : sclk_tx, spi_tx_rst (sync, active-high)
//                enable, crc_en, spi_tnum_max[12:0]   - transfer control
//                cpu_wr_valid/data/ready               - CPU write port
//                dma_wr_valid/data/ready               - DMA write port
//                tx_start                              - shifter frame pulse
//                spi_tx_data, shift_en                 - to shift engine
//                txe, busy, udr, udr_clr, done, fifo_level - status
//  Revision    : 1.0  initial release
// ============================================================================
module spi_tx_frame_ctrl #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                         sclk_tx,
  input  logic                         spi_tx_rst,
  input  logic                         enable,
  input  logic                         crc_en,
  input  logic [12:0]                  spi_tnum_max,
  input  logic                         cpu_wr_valid,
  input  logic [DW-1:0]                cpu_wr_data,
  output logic                         cpu_wr_ready,
  input  logic                         dma_wr_valid,
  input  logic [DW-1:0]                dma_wr_data,
  output logic                         dma_wr_ready,
  input  logic                         tx_start,
  output logic [DW-1:0]                spi_tx_data,
  output logic                         shift_en,
  output logic                         txe,
  output logic                         busy,
  output logic                         udr,
  input  logic                         udr_clr,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_CRC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [12:0]     r_frame_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_udr;
  logic            r_txe;
  logic            r_last_cpu;   // 1: last accepted push was CPU, 0: DMA
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [LW-1:0]   r_level;
  logic [DW-1:0]   r_head;
  logic [DW-1:0]   r_mem [DEPTH];

  logic            w_full;
  logic            w_empty;
  logic            w_cpu_gnt;
  logic            w_dma_gnt;
  logic            w_push;
  logic [DW-1:0]   w_push_data;
  logic            w_active;
  logic            w_flush;
  logic            w_frame;
  logic            w_pop;
  logic            w_udr_set;
  logic [LW-1:0]   w_remain;
  logic [LW-1:0]   w_level_nxt;
  logic [AW-1:0]   w_rd_nxt;
  logic [DW-1:0]   w_head_nxt;
  logic [12:0]     w_cnt_inc;

  // Arbitration: a lone requester wins; on a tie the side that did not win
  // the last accepted push gets the grant.
  assign w_full      = (r_level == LW'(DEPTH));
  assign w_empty     = (r_level == '0);
  assign w_cpu_gnt   = cpu_wr_valid & (~dma_wr_valid | ~r_last_cpu);
  assign w_dma_gnt   = dma_wr_valid & ~w_cpu_gnt;
  assign cpu_wr_ready = w_cpu_gnt & ~w_full;
  assign dma_wr_ready = w_dma_gnt & ~w_full;
  assign w_push      = cpu_wr_ready | dma_wr_ready;
  assign w_push_data = w_cpu_gnt ? cpu_wr_data : dma_wr_data;

  assign w_active  = (r_state == S_RUN) | (r_state == S_CRC);
  assign w_flush   = w_active & ~enable;
  assign w_frame   = (r_state == S_RUN) & enable & tx_start;
  // A frame taken from an empty FIFO is an underrun, even if a push lands
  // in the same cycle.
  assign w_pop     = w_frame & ~w_empty;
  assign w_udr_set = w_frame & w_empty;

  // Flush drops all stored entries; a push accepted in the same cycle still
  // lands so that a granted write is never lost.
  assign w_remain    = w_flush ? '0 : (r_level - {{(LW-1){1'b0}}, w_pop});
  assign w_rd_nxt    = w_flush ? r_wr_ptr : (r_rd_ptr + {{(AW-1){1'b0}}, w_pop});
  assign w_level_nxt = w_remain + {{(LW-1){1'b0}}, w_push};

  always_comb begin
    w_head_nxt = '0;
    if (w_remain != '0)
      w_head_nxt = r_mem[w_rd_nxt];
    else if (w_push)
      w_head_nxt = w_push_data;
  end

  assign w_cnt_inc = (r_frame_cnt == 13'h1FFF) ? r_frame_cnt : (r_frame_cnt + 13'd1);

  // FIFO storage carries no reset; its content is masked by the level.
  always_ff @(posedge sclk_tx) begin
    if (w_push)
      r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge sclk_tx) begin
    if (spi_tx_rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_level    <= '0;
      r_head     <= '0;
      r_txe      <= 1'b1;
      r_last_cpu <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
        r_last_cpu <= cpu_wr_ready;
      end
      r_rd_ptr <= w_rd_nxt;
      r_level  <= w_level_nxt;
      r_head   <= w_head_nxt;
      r_txe    <= (w_level_nxt == '0);
    end
  end

  // Sticky underrun: a new set in the same cycle beats the clear.
  always_ff @(posedge sclk_tx) begin
    if (spi_tx_rst)
      r_udr <= 1'b0;
    else if (w_udr_set)
      r_udr <= 1'b1;
    else if (udr_clr)
      r_udr <= 1'b0;
  end

  always_ff @(posedge sclk_tx) begin
    if (spi_tx_rst) begin
      r_state     <= S_IDLE;
      r_frame_cnt <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (enable & ~r_txe) begin
            r_state     <= S_RUN;
            r_frame_cnt <= '0;
            r_busy      <= 1'b1;
          end
        end
        S_RUN: begin
          if (~enable) begin
            r_state     <= S_IDLE;
            r_frame_cnt <= '0;
            r_busy      <= 1'b0;
          end else if (tx_start) begin
            r_frame_cnt <= w_cnt_inc;
            if ((spi_tnum_max != 13'd0) && (w_cnt_inc == spi_tnum_max)) begin
              if (crc_en) begin
                r_state <= S_CRC;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end
          end
        end
        S_CRC: begin
          if (~enable) begin
            r_state     <= S_IDLE;
            r_frame_cnt <= '0;
            r_busy      <= 1'b0;
          end else if (tx_start) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign shift_en    = w_active;
  assign spi_tx_data = r_head;
  assign txe         = r_txe;
  assign busy        = r_busy;
  assign udr         = r_udr;
  assign done        = r_done;
  assign fifo_level  = r_level;

endmodule
`default_nettype wire
